// File: rtl/square_iterate.sv
// square_iterate: multi-cycle FP16 squarer on the unpacked datapath format.
// Shift-add multiply (one partial product per cycle), then normalise, round-to-nearest-even and range-check.
`default_nettype none

module square_iterate #(
  parameter int MANT_W  = 11,
  parameter int EXP_W   = 7,
  parameter int EXP_MAX = 15,
  parameter int EXP_MIN = -14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_nan_in,
  input  logic              is_pinf_in,
  input  logic              is_ninf_in,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W-1:0] mant_in,
  output logic              out_valid,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mant_out,
  output logic              is_nan_out,
  output logic              is_pinf_out
);

  localparam int ACC_W = 2 * MANT_W;
  localparam int CNT_W = $clog2(MANT_W);
  localparam int EW    = EXP_W + 3;

  localparam logic signed [EW-1:0] E_HI     = EW'(EXP_MAX);
  localparam logic signed [EW-1:0] E_LO     = EW'(EXP_MIN);
  localparam logic [EXP_W-1:0]     EXP_INF  = EXP_W'(EXP_MAX + 1);
  localparam logic [EXP_W-1:0]     EXP_ZERO = EXP_W'(EXP_MIN - 1);
  localparam logic [MANT_W-1:0]    MANT_NAN = {2'b11, {(MANT_W-2){1'b0}}};
  localparam logic [MANT_W-1:0]    MANT_ONE = {1'b1, {(MANT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]     LAST     = CNT_W'(MANT_W - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SPEC = 3'd1,
    ITER = 3'd2,
    NORM = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state, next_state;

  logic              accept;
  logic              special_in;
  logic [CNT_W-1:0]  k;
  logic [ACC_W-1:0]  acc;
  logic [MANT_W-1:0] op_mant;
  logic [EXP_W-1:0]  op_exp;
  logic              op_nan;
  logic              op_inf;

  // Sign of the operand never reaches the result (x*x >= 0).
  logic unused_sign;
  assign unused_sign = sign_in;

  assign in_ready   = enable && (state == IDLE);
  assign accept     = in_valid && in_ready;
  assign special_in = is_nan_in || is_pinf_in || is_ninf_in ||
                      ((exp_in == EXP_ZERO) && (mant_in == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (!enable) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = special_in ? SPEC : ITER;
      SPEC: next_state = DONE;
      ITER: if (k == LAST) next_state = NORM;
      NORM: next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k       <= '0;
      acc     <= '0;
      op_mant <= '0;
      op_exp  <= '0;
      op_nan  <= 1'b0;
      op_inf  <= 1'b0;
    end else if (!enable) begin
      k       <= '0;
      acc     <= '0;
      op_mant <= '0;
      op_exp  <= '0;
      op_nan  <= 1'b0;
      op_inf  <= 1'b0;
    end else if (accept) begin
      k       <= '0;
      acc     <= '0;
      op_mant <= mant_in;
      op_exp  <= exp_in;
      op_nan  <= is_nan_in;
      op_inf  <= is_pinf_in || is_ninf_in;
    end else if (state == ITER) begin
      if (op_mant[k]) acc <= acc + (ACC_W'(op_mant) << k);
      k <= k + 1'b1;
    end
  end

  // Normalisation: product of two [1,2) mantissas lies in [1,4).
  logic              top;
  logic [MANT_W-1:0] keep;
  logic              rnd_lsb;
  logic              half;
  logic              sticky;
  logic              round_up;
  logic [MANT_W:0]   keep_rnd;
  logic [MANT_W-1:0] mant_n;
  logic [EXP_W:0]    e2;
  logic signed [EW-1:0] e_fin;
  logic              ovf;
  logic              unf;

  always_comb begin
    top      = acc[ACC_W-1];
    e2       = {op_exp, 1'b0};
    keep     = top ? acc[ACC_W-1 -: MANT_W] : acc[ACC_W-2 -: MANT_W];
    rnd_lsb  = top ? acc[MANT_W]   : acc[MANT_W-1];
    half     = top ? acc[MANT_W-1] : acc[MANT_W-2];
    sticky   = top ? (|acc[MANT_W-2:0]) : (|acc[MANT_W-3:0]);
    round_up = half && (sticky || rnd_lsb);
    keep_rnd = {1'b0, keep} + {{MANT_W{1'b0}}, round_up};
    mant_n   = keep_rnd[MANT_W] ? MANT_ONE : keep_rnd[MANT_W-1:0];
    e_fin    = {{2{e2[EXP_W]}}, e2} + EW'(top) + EW'(keep_rnd[MANT_W]);
    ovf      = e_fin > E_HI;
    unf      = e_fin < E_LO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      sign_out    <= 1'b0;
      exp_out     <= '0;
      mant_out    <= '0;
      is_nan_out  <= 1'b0;
      is_pinf_out <= 1'b0;
    end else if (!enable) begin
      out_valid   <= 1'b0;
      sign_out    <= 1'b0;
      exp_out     <= '0;
      mant_out    <= '0;
      is_nan_out  <= 1'b0;
      is_pinf_out <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == SPEC) begin
        out_valid   <= 1'b1;
        sign_out    <= 1'b0;
        is_nan_out  <= op_nan;
        is_pinf_out <= !op_nan && op_inf;
        exp_out     <= (op_nan || op_inf) ? EXP_INF : EXP_ZERO;
        mant_out    <= op_nan ? MANT_NAN : '0;
      end else if (state == NORM) begin
        out_valid   <= 1'b1;
        sign_out    <= 1'b0;
        is_nan_out  <= 1'b0;
        is_pinf_out <= ovf;
        exp_out     <= ovf ? EXP_INF : (unf ? EXP_ZERO : e_fin[EXP_W-1:0]);
        mant_out    <= (ovf || unf) ? '0 : mant_n;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_square_iterate.sv
// tb_square_iterate: directed self-checking bench for the FP16 squarer.
`default_nettype none

module tb_square_iterate;

  logic        clk = 1'b0;
  logic        rst_n, enable, in_valid, in_ready;
  logic        is_nan_in, is_pinf_in, is_ninf_in, sign_in;
  logic [6:0]  exp_in;
  logic [10:0] mant_in;
  logic        out_valid, sign_out, is_nan_out, is_pinf_out;
  logic [6:0]  exp_out;
  logic [10:0] mant_out;

  int n_checks = 0;
  int n_fail   = 0;

  square_iterate dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_nan_in(is_nan_in), .is_pinf_in(is_pinf_in), .is_ninf_in(is_ninf_in),
    .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
    .out_valid(out_valid), .sign_out(sign_out), .exp_out(exp_out), .mant_out(mant_out),
    .is_nan_out(is_nan_out), .is_pinf_out(is_pinf_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic nan, input logic pinf, input logic ninf, input logic sgn,
                       input logic [6:0] e, input logic [10:0] m);
    is_nan_in  = nan;
    is_pinf_in = pinf;
    is_ninf_in = ninf;
    sign_in    = sgn;
    exp_in     = e;
    mant_in    = m;
  endtask

  task automatic run_op(input string tag, input logic nan, input logic pinf, input logic ninf,
                        input logic sgn, input logic [6:0] e, input logic [10:0] m,
                        input int lat_exp, input logic [6:0] e_exp, input logic [10:0] m_exp,
                        input logic nan_exp, input logic inf_exp);
    int lat;
    drive(nan, pinf, ninf, sgn, e, m);
    in_valid = 1'b1;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    check({tag, "_exp"}, 32'(exp_out), 32'(e_exp));
    check({tag, "_mant"}, 32'(mant_out), 32'(m_exp));
    check({tag, "_flags"}, {30'd0, is_nan_out, is_pinf_out}, {30'd0, nan_exp, inf_exp});
    check({tag, "_sign"}, 32'(sign_out), 32'd0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int pulses;
    logic busy_rdy;
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0;
    drive(0, 0, 0, 0, 7'd0, 11'd0);
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_exp", 32'(exp_out), 32'd0);
    check("rst_mant", 32'(mant_out), 32'd0);
    check("rst_flags", {29'd0, is_nan_out, is_pinf_out, sign_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);

    // numeric path: latency 12
    run_op("sq1p5",  0, 0, 0, 0, 7'd0,  11'h600, 12, 7'd1,  11'h480, 0, 0);
    run_op("sqm2",   0, 0, 0, 1, 7'd1,  11'h400, 12, 7'd2,  11'h400, 0, 0);
    // 2047^2 = 0x3FF001: keep 0x7FE, guard 0x001 -> no round
    run_op("maxm",   0, 0, 0, 0, 7'd0,  11'h7FF, 12, 7'd1,  11'h7FE, 0, 0);
    // 1448^2 = 0x1FFE40: keep 0x7FF rounds up to 2.0
    run_op("carry",  0, 0, 0, 0, 7'd0,  11'h5A8, 12, 7'd1,  11'h400, 0, 0);
    run_op("maxfin", 0, 0, 0, 0, 7'd7,  11'h7FF, 12, 7'd15, 11'h7FE, 0, 0);
    run_op("minnrm", 0, 0, 0, 0, 7'h79, 11'h400, 12, 7'h72, 11'h400, 0, 0);
    run_op("ovf",    0, 0, 0, 0, 7'd8,  11'h400, 12, 7'd16, 11'h000, 0, 1);
    run_op("unf",    0, 0, 0, 0, 7'h78, 11'h400, 12, 7'h71, 11'h000, 0, 0);
    // specials: latency 1
    run_op("nan",    1, 0, 0, 0, 7'd16, 11'h600, 1,  7'd16, 11'h600, 1, 0);
    run_op("ninf",   0, 0, 1, 1, 7'd16, 11'h000, 1,  7'd16, 11'h000, 0, 1);
    run_op("zero",   0, 0, 0, 0, 7'h71, 11'h000, 1,  7'h71, 11'h000, 0, 0);

    // enable dropped at E5 of an iteration
    drive(0, 0, 0, 0, 7'd0, 11'h600);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin @(posedge clk); #1; end
    enable = 1'b0;
    @(posedge clk); #1;
    check("abort_rdy_off", 32'(in_ready), 32'd0);
    check("abort_mant_clr", 32'(mant_out), 32'd0);
    enable = 1'b1;
    #1;
    check("abort_rdy_on", 32'(in_ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; pulses += int'(out_valid); end
    check("abort_no_valid", 32'(pulses), 32'd0);

    // in_valid held high while busy
    drive(0, 0, 0, 0, 7'd0, 11'h600);
    in_valid = 1'b1;
    @(posedge clk); #1;
    pulses = 0;
    busy_rdy = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      pulses += int'(out_valid);
      busy_rdy |= in_ready;
    end
    in_valid = 1'b0;
    check("hold_pulses", 32'(pulses), 32'd1);
    check("hold_busy_rdy", 32'(busy_rdy), 32'd0);
    check("hold_mant", 32'(mant_out), 32'h480);
    @(posedge clk); #1;

    // async reset mid-iteration
    drive(0, 0, 0, 0, 7'd1, 11'h7FF);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mant", 32'(mant_out), 32'd0);
    check("arst_exp", 32'(exp_out), 32'd0);
    check("arst_flags", {28'd0, out_valid, is_nan_out, is_pinf_out, sign_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("post_rst", 0, 0, 0, 0, 7'd0, 11'h600, 12, 7'd1, 11'h480, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
